// File: rtl/wbuffer_drain_ctrl.sv
// Write-buffer drain sequencer: moves the FIFO head line to memory as one
// 8-beat AXI INCR burst and retires the entry only after its B response.
module wbuffer_drain_ctrl #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned HIGH_WATER = 12,
  parameter logic [3:0]  AXI_ID     = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [4:0]   ent_count,
  input  logic [26:0]  ent_paddr,
  input  logic [255:0] ent_data,
  output logic         pop,
  input  logic         drain_hint,
  input  logic         clear,
  output logic         clear_done,
  output logic         busy,
  output logic         bus_err,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  // A high-water mark above the buffer depth could never trigger; clamp it.
  localparam logic [4:0] HW_MARK = 5'((HIGH_WATER > DEPTH) ? DEPTH : HIGH_WATER);

  state_t       state;
  logic [2:0]   beat;
  logic         clr_pend;
  logic [31:0]  addr_r;
  logic [255:0] line_r;
  logic         start;
  logic         clr_req;
  logic         unused_bid;

  assign clr_req    = clr_pend | clear;
  assign start      = (ent_count != 5'd0) && (clr_req || (ent_count >= HW_MARK) || drain_hint);
  assign unused_bid = ^bid;

  assign awid    = AXI_ID;
  assign awaddr  = addr_r;
  assign awlen   = 8'd7;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = AXI_ID;
  assign wstrb   = '1;
  assign wdata   = line_r[{beat, 5'b0} +: 32];

  // pop must coincide with the B handshake so the storage has updated
  // ent_count by the single IDLE cycle that follows.
  assign pop = resetn && (state == S_B) && bvalid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      beat       <= '0;
      clr_pend   <= 1'b0;
      bus_err    <= 1'b0;
      clear_done <= 1'b0;
      busy       <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      wlast      <= 1'b0;
      bready     <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      // clear is still held in the clear_done cycle; ignore it there.
      clr_pend   <= clear_done ? 1'b0 : clr_req;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_r  <= {ent_paddr, 5'b0};
            line_r  <= ent_data;
            awvalid <= 1'b1;
            busy    <= 1'b1;
            state   <= S_AW;
          end else if (clr_req && (ent_count == 5'd0) && !clear_done) begin
            clear_done <= 1'b1;
          end
        end
        S_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wlast   <= 1'b0;
            beat    <= '0;
            state   <= S_W;
          end
        end
        S_W: begin
          if (wready) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end else begin
              wlast <= (beat == 3'd6);
            end
          end
        end
        S_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            busy   <= 1'b0;
            if (bresp != 2'b00) bus_err <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
